// File: rtl/cpu_branch_unit.sv
// Execute-stage control-transfer resolver: captures one branch/JAL/JALR request,
// evaluates it in a single EVAL cycle, then holds the response and fetch redirect
// until both are taken. Define CPU_BRANCH_UNIT_STATS_EN to build the stat counters.
module cpu_branch_unit #(
  parameter int              XLEN          = 32,
  parameter logic [XLEN-1:0] RESET_PC_LINK = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_kind,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [XLEN-1:0] req_pc,
  input  logic [XLEN-1:0] req_imm,
  input  logic            req_pred_taken,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_taken,
  output logic [XLEN-1:0] resp_target,
  output logic [XLEN-1:0] resp_link,
  output logic            resp_mispredict,
  output logic            resp_illegal,
  output logic            resp_misaligned,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ack,
  output logic            flush,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
);

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  localparam logic [1:0] KIND_BRANCH = 2'b00;
  localparam logic [1:0] KIND_JAL    = 2'b01;
  localparam logic [1:0] KIND_JALR   = 2'b10;

  state_t          state_q;
  logic [1:0]      kind_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] rs1_q, rs2_q, pc_q, imm_q;
  logic            pred_q;

  logic            cond_taken, cond_illegal;
  logic            taken, illegal, misaligned, mispredict;
  logic [XLEN-1:0] taken_target, link, target, jalr_sum;

  // NOTE: every variable gets a default at the top so no path leaves one unassigned (no latch).
  always_comb begin
    cond_taken   = 1'b0;
    cond_illegal = 1'b0;
    case (funct3_q)
      3'b000:  cond_taken = (rs1_q == rs2_q);
      3'b001:  cond_taken = (rs1_q != rs2_q);
      3'b100:  cond_taken = ($signed(rs1_q) <  $signed(rs2_q));
      3'b101:  cond_taken = ($signed(rs1_q) >= $signed(rs2_q));
      3'b110:  cond_taken = (rs1_q <  rs2_q);
      3'b111:  cond_taken = (rs1_q >= rs2_q);
      default: cond_illegal = 1'b1;
    endcase
  end

  always_comb begin
    taken        = 1'b0;
    illegal      = 1'b0;
    jalr_sum     = rs1_q + imm_q;
    taken_target = pc_q + imm_q;
    link         = pc_q + XLEN'(4);
    case (kind_q)
      KIND_BRANCH: begin
        taken   = cond_taken;
        illegal = cond_illegal;
      end
      KIND_JAL:  taken = 1'b1;
      KIND_JALR: begin
        taken        = 1'b1;
        taken_target = {jalr_sum[XLEN-1:1], 1'b0};
      end
      default:   illegal = 1'b1;
    endcase
    target     = taken ? taken_target : link;
    misaligned = taken & (target[1:0] != 2'b00);
    // JALR targets are never predicted by fetch, so they always redirect when legal.
    mispredict = ((kind_q == KIND_JALR) ? 1'b1 : (taken != pred_q)) & ~illegal & ~misaligned;
  end

  // A valid output register doubles as the "not yet done" flag of its handshake.
  logic resp_hs, redirect_hs, resp_done, redirect_done;
  assign resp_hs       = resp_valid & resp_ready;
  assign redirect_hs   = redirect_valid & redirect_ack;
  assign resp_done     = ~resp_valid | resp_hs;
  assign redirect_done = ~redirect_valid | redirect_hs;

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      req_ready       <= 1'b1;
      kind_q          <= '0;
      funct3_q        <= '0;
      rs1_q           <= '0;
      rs2_q           <= '0;
      pc_q            <= '0;
      imm_q           <= '0;
      pred_q          <= 1'b0;
      resp_valid      <= 1'b0;
      resp_taken      <= 1'b0;
      resp_target     <= '0;
      resp_link       <= RESET_PC_LINK;
      resp_mispredict <= 1'b0;
      resp_illegal    <= 1'b0;
      resp_misaligned <= 1'b0;
      redirect_valid  <= 1'b0;
      redirect_pc     <= RESET_PC_LINK;
      flush           <= 1'b0;
    end else begin
      flush <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            kind_q    <= req_kind;
            funct3_q  <= req_funct3;
            rs1_q     <= req_rs1;
            rs2_q     <= req_rs2;
            pc_q      <= req_pc;
            imm_q     <= req_imm;
            pred_q    <= req_pred_taken;
            req_ready <= 1'b0;
            state_q   <= EVAL;
          end
        end
        EVAL: begin
          resp_valid      <= 1'b1;
          resp_taken      <= taken;
          resp_target     <= target;
          resp_link       <= link;
          resp_mispredict <= mispredict;
          resp_illegal    <= illegal;
          resp_misaligned <= misaligned;
          redirect_valid  <= mispredict;
          redirect_pc     <= target;
          flush           <= mispredict;
          state_q         <= RESP;
        end
        RESP: begin
          if (resp_hs)     resp_valid     <= 1'b0;
          if (redirect_hs) redirect_valid <= 1'b0;
          if (resp_done && redirect_done) begin
            req_ready <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CPU_BRANCH_UNIT_STATS_EN
  logic [31:0] branches_q, mispredicts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else begin
      if (resp_hs && kind_q == KIND_BRANCH && !resp_illegal && branches_q != '1)
        branches_q <= branches_q + 32'd1;
      if (redirect_hs && mispredicts_q != '1)
        mispredicts_q <= mispredicts_q + 32'd1;
    end
  end

  assign stat_branches    = branches_q;
  assign stat_mispredicts = mispredicts_q;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_cpu_branch_unit.sv
// Directed bench for cpu_branch_unit: a vector table for single-request results
// plus hand sequences for back-pressure, split handshakes, mid-RESP reset and stats.
module tb_cpu_branch_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0, req_ready;
  logic [1:0]      req_kind = '0;
  logic [2:0]      req_funct3 = '0;
  logic [XLEN-1:0] req_rs1 = '0, req_rs2 = '0, req_pc = '0, req_imm = '0;
  logic            req_pred_taken = 1'b0;
  logic            resp_valid, resp_ready = 1'b0, resp_taken;
  logic [XLEN-1:0] resp_target, resp_link;
  logic            resp_mispredict, resp_illegal, resp_misaligned;
  logic            redirect_valid, redirect_ack = 1'b0;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic [31:0]     stat_branches, stat_mispredicts;

  cpu_branch_unit #(.XLEN(XLEN), .RESET_PC_LINK('0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_funct3(req_funct3),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_pc(req_pc), .req_imm(req_imm),
    .req_pred_taken(req_pred_taken),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_taken(resp_taken),
    .resp_target(resp_target), .resp_link(resp_link),
    .resp_mispredict(resp_mispredict), .resp_illegal(resp_illegal),
    .resp_misaligned(resp_misaligned),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ack(redirect_ack),
    .flush(flush), .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  kind;
    logic [2:0]  f3;
    logic [31:0] rs1, rs2, pc, imm;
    logic        pred;
    logic        taken;
    logic [31:0] target, link;
    logic        mis, ill, misal;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] kind, input logic [2:0] f3,
                              input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [31:0] pc, input logic [31:0] imm, input logic pred,
                              input logic taken, input logic [31:0] target,
                              input logic mis, input logic ill, input logic misal);
    vec_t v;
    v.kind = kind; v.f3 = f3; v.rs1 = rs1; v.rs2 = rs2; v.pc = pc; v.imm = imm;
    v.pred = pred; v.taken = taken; v.target = target; v.link = pc + 32'd4;
    v.mis = mis; v.ill = ill; v.misal = misal;
    return v;
  endfunction

  // Waits (bounded) for req_ready, presents the request for one cycle, and
  // returns at the negedge of the EVAL cycle (N+1).
  task automatic drive_req(input vec_t v);
    int budget = 0;
    @(negedge clk);
    while (!req_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check("req_ready_wait", req_ready, 1);
    req_kind = v.kind; req_funct3 = v.f3; req_rs1 = v.rs1; req_rs2 = v.rs2;
    req_pc = v.pc; req_imm = v.imm; req_pred_taken = v.pred;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic check_resp(input string tag, input vec_t v);
    check({tag, " resp_valid"},  resp_valid, 1);
    check({tag, " taken"},       resp_taken, v.taken);
    check({tag, " target"},      resp_target, v.target);
    check({tag, " link"},        resp_link, v.link);
    check({tag, " mispredict"},  resp_mispredict, v.mis);
    check({tag, " illegal"},     resp_illegal, v.ill);
    check({tag, " misaligned"},  resp_misaligned, v.misal);
    check({tag, " redir_valid"}, redirect_valid, v.mis);
    check({tag, " redir_pc"},    redirect_pc, v.target);
    check({tag, " flush"},       flush, v.mis);
    check({tag, " req_ready"},   req_ready, 0);
  endtask

  // Full transaction with both handshakes completed in the first RESP cycle.
  task automatic run_vec(input string tag, input vec_t v);
    drive_req(v);
    check({tag, " eval resp_valid"}, resp_valid, 0);
    check({tag, " eval req_ready"},  req_ready, 0);
    check({tag, " eval flush"},      flush, 0);
    @(negedge clk);
    check_resp(tag, v);
    resp_ready = 1'b1;
    redirect_ack = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    redirect_ack = 1'b0;
    check({tag, " done resp_valid"},  resp_valid, 0);
    check({tag, " done redir_valid"}, redirect_valid, 0);
    check({tag, " done req_ready"},   req_ready, 1);
    check({tag, " done flush"},       flush, 0);
  endtask

  vec_t vecs[13];
  vec_t v_beq, v_bad;

  initial begin
    vecs[0]  = mk(2'b00, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 0, 1, 32'h120, 1, 0, 0);
    vecs[1]  = mk(2'b00, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1, 1, 32'h210, 0, 0, 0);
    vecs[2]  = mk(2'b00, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1, 0, 32'h204, 1, 0, 0);
    vecs[3]  = mk(2'b10, 3'b000, 32'h2003, 32'd0, 32'h40, 32'h0, 0, 1, 32'h2002, 0, 0, 1);
    vecs[4]  = mk(2'b00, 3'b010, 32'd1, 32'd1, 32'h300, 32'h40, 1, 0, 32'h304, 0, 1, 0);
    vecs[5]  = mk(2'b00, 3'b001, 32'd3, 32'd4, 32'h80, 32'hFFFF_FFF0, 1, 1, 32'h70, 0, 0, 0);
    vecs[6]  = mk(2'b00, 3'b101, 32'd1, 32'hFFFF_FFFF, 32'h1000, 32'h8, 0, 1, 32'h1008, 1, 0, 0);
    vecs[7]  = mk(2'b00, 3'b111, 32'd1, 32'hFFFF_FFFF, 32'h1000, 32'h8, 0, 0, 32'h1004, 0, 0, 0);
    vecs[8]  = mk(2'b01, 3'b000, 32'd0, 32'd0, 32'h500, 32'h100, 1, 1, 32'h600, 0, 0, 0);
    vecs[9]  = mk(2'b01, 3'b000, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'h8, 0, 1, 32'h4, 1, 0, 0);
    vecs[10] = mk(2'b11, 3'b000, 32'd0, 32'd0, 32'h10, 32'h40, 1, 0, 32'h14, 0, 1, 0);
    vecs[11] = mk(2'b00, 3'b000, 32'd7, 32'd7, 32'h100, 32'h2, 0, 1, 32'h102, 0, 0, 1);
    vecs[12] = mk(2'b10, 3'b000, 32'h1000, 32'd0, 32'h60, 32'h11, 1, 1, 32'h1010, 1, 0, 0);
    v_beq = vecs[0];
    v_bad = vecs[4];

    // Reset state
    #12;
    check("rst req_ready",   req_ready, 1);
    check("rst resp_valid",  resp_valid, 0);
    check("rst redir_valid", redirect_valid, 0);
    check("rst flush",       flush, 0);
    check("rst resp_link",   resp_link, 0);
    check("rst redirect_pc", redirect_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Illegal funct3 with the consumer stalling: fields must hold.
    drive_req(v_bad);
    @(negedge clk);
    check_resp("stall", v_bad);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d resp_valid", i), resp_valid, 1);
      check($sformatf("stall%0d illegal", i),    resp_illegal, 1);
      check($sformatf("stall%0d target", i),     resp_target, 32'h304);
      check($sformatf("stall%0d req_ready", i),  req_ready, 0);
      check($sformatf("stall%0d flush", i),      flush, 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("stall end resp_valid", resp_valid, 0);
    check("stall end req_ready",  req_ready, 1);

    // Split handshakes: redirect_ack at N+3, resp_ready at N+5.
    drive_req(v_beq);
    @(negedge clk);
    check_resp("split", v_beq);
    @(negedge clk);
    check("split n3 redir_valid", redirect_valid, 1);
    check("split n3 flush",       flush, 0);
    redirect_ack = 1'b1;
    @(negedge clk);
    redirect_ack = 1'b0;
    check("split n4 redir_valid", redirect_valid, 0);
    check("split n4 resp_valid",  resp_valid, 1);
    check("split n4 req_ready",   req_ready, 0);
    @(negedge clk);
    check("split n5 resp_valid", resp_valid, 1);
    check("split n5 target",     resp_target, 32'h120);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("split n6 resp_valid", resp_valid, 0);
    check("split n6 req_ready",  req_ready, 1);

    // Reset while RESP holds a pending redirect.
    drive_req(v_beq);
    @(negedge clk);
    check("rstmid redir_valid pre", redirect_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rstmid resp_valid",  resp_valid, 0);
    check("rstmid redir_valid", redirect_valid, 0);
    check("rstmid req_ready",   req_ready, 1);
    check("rstmid flush",       flush, 0);
    check("rstmid redirect_pc", redirect_pc, 0);
    check("rstmid stat_br",     stat_branches, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Three branches, one mispredicted.
    run_vec("st0", vecs[1]);
    run_vec("st1", vecs[0]);
    run_vec("st2", vecs[7]);
`ifdef CPU_BRANCH_UNIT_STATS_EN
    check("stat_branches",    stat_branches, 3);
    check("stat_mispredicts", stat_mispredicts, 1);
`else
    check("stat_branches tied",    stat_branches, 0);
    check("stat_mispredicts tied", stat_mispredicts, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
